// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch path: FSM encodings, instruction size,
// default reset vector and the modulo-2^32 next-instruction helper.
package fetch_pkg;

  localparam logic [31:0] INSN_BYTES         = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_HOLD = 2'd3;

  // Wraps silently past 32'hFFFF_FFFC.
  function automatic logic [31:0] next_insn_addr(input logic [31:0] addr);
    return addr + INSN_BYTES;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Architectural program counter with its next-pc mux:
// reset / redirect load / sequential advance / hold.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (advance) begin
      pc_d = next_insn_addr(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch sequencer: one outstanding request to instruction memory,
// returns each fetched word with its pc, and takes aligned redirects.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
  parameter int          XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err
);

  state_t          state_d, state_q;
  logic            drop_d, drop_q;
  logic            inst_valid_d, inst_valid_q;
  logic [XLEN-1:0] inst_d, inst_q;
  logic [XLEN-1:0] inst_pc_d, inst_pc_q;
  logic            misalign_d, misalign_q;
  logic            redir_ok;
  logic            pc_advance;
  logic [31:0]     pc;

  assign redir_ok = redirect_valid && (redirect_addr[1:0] == 2'b00);

  pc_reg #(
    .RESET_ADDR(RESET_ADDR)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (redir_ok),
    .load_addr(redirect_addr),
    .advance  (pc_advance),
    .pc       (pc)
  );

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q && stall;
    misalign_d   = redirect_valid && (redirect_addr[1:0] != 2'b00);
    pc_advance   = 1'b0;
    if (redir_ok) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // A redirect racing an accepted request must discard that response.
        if (imem_ready) begin
          state_d = ST_WAIT;
          drop_d  = redir_ok;
        end
      end
      ST_WAIT: begin
        if (redir_ok) begin
          if (imem_rsp_valid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = pc;
            inst_valid_d = 1'b1;
            pc_advance   = 1'b1;
            state_d      = stall ? ST_HOLD : ST_REQ;
          end
        end
      end
      default: begin
        if (redir_ok || !stall) begin
          state_d = ST_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req     = (state_q == ST_REQ);
  assign imem_addr    = pc;
  assign inst_valid   = inst_valid_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign pc_plus4     = next_insn_addr(inst_pc_q);
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against
// a program-order scoreboard and a latency-configurable memory model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, imem_ready, imem_rsp_valid;
  logic [31:0] redirect_addr, imem_rsp_data;
  logic        imem_req, inst_valid, misalign_err;
  logic [31:0] imem_addr, inst, inst_pc, pc_plus4;

  logic        rst_w, stall_w, redirect_valid_w, imem_ready_w, imem_rsp_valid_w;
  logic [31:0] redirect_addr_w, imem_rsp_data_w;
  logic        imem_req_w, inst_valid_w, misalign_err_w;
  logic [31:0] imem_addr_w, inst_w, inst_pc_w, pc_plus4_w;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_ADDR(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .pc_plus4(pc_plus4), .misalign_err(misalign_err)
  );

  fetch_pc_unit #(.RESET_ADDR(32'hFFFF_FFFC), .XLEN(32)) dut_wrap (
    .clk(clk), .rst(rst_w), .stall(stall_w),
    .redirect_valid(redirect_valid_w), .redirect_addr(redirect_addr_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ready(imem_ready_w),
    .imem_rsp_valid(imem_rsp_valid_w), .imem_rsp_data(imem_rsp_data_w),
    .inst_valid(inst_valid_w), .inst(inst_w), .inst_pc(inst_pc_w),
    .pc_plus4(pc_plus4_w), .misalign_err(misalign_err_w)
  );

  int total = 0;
  int bad   = 0;

  // Memory model and program-order scoreboard state.
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          lat = 1;
  logic        junk_en = 1'b0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_next = 32'h0;
  logic        exp_mis = 1'b0;
  logic        prev_valid = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_pc = '0;
  int          n_new = 0;

  // Memory contents: a bijection of the address whose bits 17:16 are always 2'b10.
  function automatic logic [31:0] h(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic aligned_redir;
    @(negedge clk);
    aligned_redir = redirect_valid && (redirect_addr[1:0] == 2'b00);
    if (mon_en) begin
      chk("pc_plus4", pc_plus4, inst_pc + 32'd4);
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
      if (inst_valid) begin
        chk("inst_data", inst, h(inst_pc));
        if (!prev_valid || !prev_stall || inst_pc != prev_pc) begin
          chk("inst_order", inst_pc, exp_next);
          exp_next = inst_pc + 32'd4;
          n_new++;
        end
      end
      if (imem_req && imem_ready) begin
        chk("single_outstanding", {31'b0, pend}, 32'd0);
        if (!aligned_redir) chk("req_addr", imem_addr, exp_next);
      end
    end
    if (imem_req && imem_ready) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = lat;
    end
    exp_mis = !rst && redirect_valid && (redirect_addr[1:0] != 2'b00);
    if (rst) begin
      exp_next   = 32'h0;
      prev_valid = 1'b0;
    end else begin
      if (aligned_redir) exp_next = redirect_addr;
      prev_valid = inst_valid;
      prev_stall = stall;
      prev_pc    = inst_pc;
    end
    @(posedge clk);
    #1;
    mon_en         = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = h(pend_addr);
        pend           = 1'b0;
      end
    end else if (junk_en && ($urandom % 8 == 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = h($urandom) ^ 32'h0003_0000;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_mis"}, {31'b0, misalign_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    imem_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    rst_w = 1'b1; stall_w = 1'b0; redirect_valid_w = 1'b0; redirect_addr_w = '0;
    imem_ready_w = 1'b0; imem_rsp_valid_w = 1'b0; imem_rsp_data_w = '0;
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    chk_reset_outputs("reset");                                 // c0
    cycle();
    chk("c1_req", {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    cycle();
    cycle();
    chk("c3_valid", {31'b0, inst_valid}, 32'd1);
    chk("c3_inst_pc", inst_pc, 32'h0);
    chk("c3_pc_plus4", pc_plus4, 32'h4);
    chk("c3_addr", imem_addr, 32'h4);
    cycle();
    stall = 1'b1;                                               // c4
    for (int k = 0; k < 4; k++) begin
      cycle();                                                  // c5..c8
      if (k == 3) begin
        stall = 1'b0;
        lat = 2;
      end
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_inst_pc", inst_pc, 32'h4);
      chk("hold_inst", inst, h(32'h4));
      chk("hold_no_req", {31'b0, imem_req}, 32'd0);
    end
    cycle();
    chk("c9_req", {31'b0, imem_req}, 32'd1);
    chk("c9_addr", imem_addr, 32'h8);
    cycle();
    redirect_valid = 1'b1; redirect_addr = 32'h100;             // c10
    chk("c10_req", {31'b0, imem_req}, 32'd0);
    cycle();
    redirect_valid = 1'b0; lat = 1;                             // c11
    chk("c11_valid", {31'b0, inst_valid}, 32'd0);
    cycle();
    chk("c12_valid", {31'b0, inst_valid}, 32'd0);
    chk("c12_addr", imem_addr, 32'h100);
    chk("c12_req", {31'b0, imem_req}, 32'd1);
    cycle();
    cycle();
    chk("c14_inst_pc", inst_pc, 32'h100);
    chk("c14_inst", inst, h(32'h100));
    chk("c14_addr", imem_addr, 32'h104);
    redirect_valid = 1'b1; redirect_addr = 32'h102;
    cycle();
    redirect_valid = 1'b0; lat = 2;                             // c15
    chk("c15_misalign", {31'b0, misalign_err}, 32'd1);
    cycle();
    chk("c16_misalign", {31'b0, misalign_err}, 32'd0);
    chk("c16_inst_pc", inst_pc, 32'h104);
    chk("c16_addr", imem_addr, 32'h108);
    cycle();
    rst = 1'b1;                                                 // c17
    chk("c17_req", {31'b0, imem_req}, 32'd0);
    cycle();
    rst = 1'b0; lat = 1;                                        // c18
    chk("c18_stale_rsp", {31'b0, imem_rsp_valid}, 32'd1);
    chk_reset_outputs("midrst");
    cycle();
    chk("c19_valid", {31'b0, inst_valid}, 32'd0);
    chk("c19_addr", imem_addr, 32'h0);
    chk("c19_req", {31'b0, imem_req}, 32'd1);
    cycle();
    cycle();
    chk("c21_inst_pc", inst_pc, 32'h0);
    chk("c21_inst", inst, h(32'h0));

    junk_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall          = ($urandom % 4) == 0;
      imem_ready     = ($urandom % 3) != 0;
      lat            = $urandom_range(1, 3);
      redirect_valid = ($urandom % 12) == 0;
      r = $urandom;
      case (r[14:13])
        2'd0:    redirect_addr = {r[31:2], 2'b00};
        2'd1:    redirect_addr = 32'hFFFF_FFF8;
        2'd2:    redirect_addr = {r[31:2], r[1:0] | 2'b01};
        default: redirect_addr = {22'h0, r[9:2], 2'b00};
      endcase
      rst = !pend && (($urandom % 200) == 0);
      if (rst) imem_ready = 1'b0;
      cycle();
    end
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b1; junk_en = 1'b0;
    chk("progress", {31'b0, (n_new > 100)}, 32'd1);

    cycle();
    rst_w = 1'b0;
    chk("wrap_reset_addr", imem_addr_w, 32'hFFFF_FFFC);
    chk("wrap_reset_req", {31'b0, imem_req_w}, 32'd0);
    imem_ready_w = 1'b1;
    cycle();
    chk("wrap_req", {31'b0, imem_req_w}, 32'd1);
    chk("wrap_req_addr", imem_addr_w, 32'hFFFF_FFFC);
    cycle();
    imem_rsp_valid_w = 1'b1; imem_rsp_data_w = h(32'hFFFF_FFFC);
    cycle();
    imem_rsp_valid_w = 1'b0;
    chk("wrap_valid", {31'b0, inst_valid_w}, 32'd1);
    chk("wrap_inst_pc", inst_pc_w, 32'hFFFF_FFFC);
    chk("wrap_inst", inst_w, h(32'hFFFF_FFFC));
    chk("wrap_pc_plus4", pc_plus4_w, 32'h0);
    chk("wrap_next_addr", imem_addr_w, 32'h0);
    chk("wrap_next_req", {31'b0, imem_req_w}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
